gaussian_blur_stream: RTL
=========================

# gaussian_blur_stream

Streaming 3x3 Gaussian blur (kernel 1 2 1 / 2 4 2 / 1 2 1, divide by 16) for a raster pixel stream, parametrised in pixel width and image geometry. It contains its own line buffers and window registers, so it accepts one pixel per valid cycle directly from the camera or frame-reader path. It emits the blurred interior image, with frame and line markers, to the gradient stage of the Canny pipeline. A runtime bypass passes the window centre through unfiltered.

## Interface
- DATA_W, 8, pixel width in bits (unsigned)
- IMG_W, 640, pixels per line, min 3
- IMG_H, 480, lines per frame, min 3
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  in_data is a valid pixel this cycle; gaps allowed, no backpressure
- in_sof  in  1  qualified by in_valid; this pixel is (row 0, col 0)
- in_data  in  DATA_W  input pixel, raster order
- bypass  in  1  1 = output the centre pixel unfiltered; sampled with in_valid
- out_valid  out  1  out_data valid
- out_data  out  DATA_W  blurred (or bypassed) pixel
- out_sof  out  1  first output of frame, centre (1,1)
- out_eol  out  1  last output of line, centre column IMG_W-2
- out_eof  out  1  last output of frame, centre (IMG_H-2, IMG_W-2)

## Operation
- Column counter col (0..IMG_W-1) and row counter row (0..IMG_H-1) advance on each in_valid.
  - col wraps to 0 and row increments at IMG_W-1.
  - At (IMG_H-1, IMG_W-1) both wrap to 0.
- in_sof with in_valid forces that pixel to (0,0), even mid-frame. Stale line-buffer data is ignored because of the row gating below.
- Two line buffers of IMG_W x DATA_W hold rows row-1 and row-2, addressed by col.
  - On each in_valid: buffer1[col] moves to buffer2[col], and in_data is written to buffer1[col].
- The 3x3 window shift register shifts one column per in_valid. New column = {buffer2[col], buffer1[col], in_data}.
- When the pixel at (r,c) is accepted, the window is centred on (r-1, c-1). The window is valid only when r>=2 and c>=2.
  - Output image is (IMG_H-2) x (IMG_W-2).
  - No border pixels are emitted.
  - Window shifts across line boundaries are harmless because of the c>=2 gating.
- Stage 1 sum: width DATA_W+4, computed unsigned with no overflow.
- Stage 2 output:
  - With bypass: the centre pixel.
  - Otherwise: sum>>4, or (sum+8)>>4 when rounding is enabled (see Configuration).
  - The result is at most 2^DATA_W-1, so no saturation is needed.
- Markers are computed from the window centre coordinates and travel with the data:
  - out_sof: centre (1,1)
  - out_eol: centre col IMG_W-2
  - out_eof: out_eol at centre row IMG_H-2
- Reset values: out_valid, out_data, out_sof, out_eol, out_eof, row and col all 0. Pipeline valid flags are cleared.
  - Line buffer contents are not reset.
  - Reset mid-frame discards the partial frame. The first pixel after reset is treated as (0,0) whether or not in_sof is set.

## Timing
- Latency: exactly 2 clk from the accepting in_valid edge to the out_valid edge (stage 1 registers the window/sum, stage 2 registers out_*).
- Throughput: 1 pixel/clk; input gaps propagate 1:1 as out_valid gaps. The pipeline advances every clock, not only on in_valid.
- out_valid is a single-cycle pulse per output pixel. Markers are valid only with out_valid and are otherwise 0.
- bypass is registered with its pixel, so a change takes effect for that pixel's output with no glitch on in-flight pixels.
- Line buffer: one-cycle synchronous RAM permitted. Read-before-write at the same address is required.

## Configuration
- GAUSS_ROUND_EN defined: filtered output = (sum + 8) >> 4, round half up.
- GAUSS_ROUND_EN undefined: filtered output = sum >> 4, truncation, matching the legacy unpipelined filter bit-exactly.
- The macro has no effect on bypass output, latency or markers.

## Test plan
- All tests use IMG_W=8, IMG_H=6, DATA_W=8.
- Flat frame of 100, continuous valid:
  - 24 outputs, all 100.
  - out_sof on the 1st output, out_eol every 6th, out_eof on the 24th.
  - First out_valid 2 clk after the pixel (2,2) input.
- Impulse 160 at (2,2), all others 0:
  - centre (2,2) = 40; centres (1,2), (2,1), (2,3), (3,2) = 20; diagonal centres = 10; all others 0.
- Rounding: single 2 at (3,3), all others 0.
  - Centre (3,3) = 1 with GAUSS_ROUND_EN, 0 without.
- Bypass: ramp frame in_data = 8*row + col, bypass=1 for row 3 only.
  - Outputs centred on row 3 equal 8*3 + centre col.
  - Outputs on other rows are filtered; for a linear ramp, filtered equals centre value.
- Random in_valid gaps of 0-3 cycles on the flat/impulse frames: identical data and markers, each output exactly 2 clk after its triggering input.
- Restart events:
  - in_sof asserted at (3,4) of frame 1: no output until that new frame's (2,2); the new frame's outputs are correct.
  - rst asserted for 1 cycle mid-frame: all outputs 0 next cycle, then correct results for the following frame.

Source files
------------

// File: rtl/gaussian_blur_stream_if.sv
// Pixel stream bundle for gaussian_blur_stream: raster input with frame
// start and bypass, blurred output with frame/line markers.
// master = pixel source / result sink, slave = the blur block.
interface gaussian_blur_stream_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic              in_sof;
  logic [DATA_W-1:0] in_data;
  logic              bypass;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_sof;
  logic              out_eol;
  logic              out_eof;

  modport master (
    output in_valid, in_sof, in_data, bypass,
    input  out_valid, out_data, out_sof, out_eol, out_eof
  );

  modport slave (
    input  in_valid, in_sof, in_data, bypass,
    output out_valid, out_data, out_sof, out_eol, out_eof
  );
endinterface

// File: rtl/gaussian_blur_stream.sv
// Streaming 3x3 Gaussian blur (1 2 1 / 2 4 2 / 1 2 1, /16) with internal
// line buffers. Emits only the interior (IMG_H-2)x(IMG_W-2) image with
// sof/eol/eof markers, 2 clk after the accepting edge.
// Optional macro GAUSS_ROUND_EN: round half up instead of truncating.
module gaussian_blur_stream #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480
) (
  input logic             clk,
  input logic             rst,
  gaussian_blur_stream_if.slave px
);
  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int SUM_W = DATA_W + 4;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

  // Filtered sum to output pixel; max sum+8 is below 2^SUM_W, so no overflow.
  function automatic logic [DATA_W-1:0] scale_sum(input logic [SUM_W-1:0] s);
    logic [SUM_W-1:0] t;
`ifdef GAUSS_ROUND_EN
    t = s + SUM_W'(8);
`else
    t = s;
`endif
    return DATA_W'(t >> 4);
  endfunction

  logic [COL_W-1:0]  col, col_cur;
  logic [ROW_W-1:0]  row, row_cur;
  logic              sof_in;

  logic [DATA_W-1:0] lb1 [IMG_W];
  logic [DATA_W-1:0] lb2 [IMG_W];

  logic [DATA_W-1:0] win_p0 [3][3];
  logic              vld_p0, byp_p0, sof_p0, eol_p0, eof_p0;
  logic [SUM_W-1:0]  sum_c;

  logic [SUM_W-1:0]  sum_p1;
  logic [DATA_W-1:0] ctr_p1;
  logic              vld_p1, byp_p1, sof_p1, eol_p1, eof_p1;

  // Position of the pixel being accepted; in_sof restarts the raster.
  always_comb begin
    sof_in  = px.in_valid && px.in_sof;
    col_cur = sof_in ? '0 : col;
    row_cur = sof_in ? '0 : row;
  end

  // Raster counters advance once per accepted pixel and wrap at frame end.
  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (px.in_valid) begin
      if (col_cur == COL_LAST) begin
        col <= '0;
        row <= (row_cur == ROW_LAST) ? '0 : row_cur + ROW_W'(1);
      end else begin
        col <= col_cur + COL_W'(1);
        row <= row_cur;
      end
    end
  end

  // ---- stage 0: line buffers (read-before-write) and window shift ----
  // Line buffers, window columns and per-pixel tags move on in_valid only.
  always_ff @(posedge clk) begin
    if (px.in_valid) begin
      lb2[col_cur] <= lb1[col_cur];
      lb1[col_cur] <= px.in_data;
      for (int i = 0; i < 3; i++) begin
        win_p0[i][0] <= win_p0[i][1];
        win_p0[i][1] <= win_p0[i][2];
      end
      win_p0[0][2] <= lb2[col_cur];
      win_p0[1][2] <= lb1[col_cur];
      win_p0[2][2] <= px.in_data;
      byp_p0 <= px.bypass;
      sof_p0 <= (row_cur == ROW_TWO) && (col_cur == COL_TWO);
      eol_p0 <= (col_cur == COL_LAST);
      eof_p0 <= (col_cur == COL_LAST) && (row_cur == ROW_LAST);
    end
  end

  // Window is valid only once two rows and two columns of context exist.
  always_ff @(posedge clk) begin
    if (rst) vld_p0 <= 1'b0;
    else     vld_p0 <= px.in_valid && (row_cur >= ROW_TWO) && (col_cur >= COL_TWO);
  end

  // Weighted 3x3 sum: corners x1, edges x2, centre x4.
  always_comb begin
    sum_c = SUM_W'(win_p0[0][0]) + SUM_W'(win_p0[0][2])
          + SUM_W'(win_p0[2][0]) + SUM_W'(win_p0[2][2])
          + ((SUM_W'(win_p0[0][1]) + SUM_W'(win_p0[1][0])
            + SUM_W'(win_p0[1][2]) + SUM_W'(win_p0[2][1])) << 1)
          + (SUM_W'(win_p0[1][1]) << 2);
  end

  // ---- stage 1: registered sum, centre pixel and tags ----
  // Data path of stage 1 runs every clock.
  always_ff @(posedge clk) begin
    sum_p1 <= sum_c;
    ctr_p1 <= win_p0[1][1];
    byp_p1 <= byp_p0;
    sof_p1 <= sof_p0;
    eol_p1 <= eol_p0;
    eof_p1 <= eof_p0;
  end

  // Stage 1 valid.
  always_ff @(posedge clk) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= vld_p0;
  end

  // ---- stage 2: output registers ----
  // Markers are gated by valid; data updates only for real output pixels.
  always_ff @(posedge clk) begin
    if (rst) begin
      px.out_valid <= 1'b0;
      px.out_data  <= '0;
      px.out_sof   <= 1'b0;
      px.out_eol   <= 1'b0;
      px.out_eof   <= 1'b0;
    end else begin
      px.out_valid <= vld_p1;
      px.out_sof   <= vld_p1 && sof_p1;
      px.out_eol   <= vld_p1 && eol_p1;
      px.out_eof   <= vld_p1 && eof_p1;
      if (vld_p1) px.out_data <= byp_p1 ? ctr_p1 : scale_sum(sum_p1);
    end
  end
endmodule
